// File: rtl/nibble_scan_pkg.sv
// Shared definitions for the nibble scan sequencer: widths, channel count,
// the sequencer state encoding and a small channel-index helper.
package nibble_scan_pkg;

    localparam int NIB_W = 4;   // width of one channel nibble
    localparam int CH_N  = 16;  // channels in the bank / mux inputs
    localparam int CH_W  = 4;   // width of a channel index

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        DRAIN = 2'd2
    } scan_state_e;

    // Next channel of a pass; wraps to 0 after the last scanned channel.
    function automatic logic [CH_W-1:0] next_ch(input logic [CH_W-1:0] ch,
                                                input logic [CH_W-1:0] last);
        logic [CH_W-1:0] nxt;
        nxt = ch + CH_W'(1);
        if (ch == last) begin
            nxt = '0;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/nibble_bank.sv
// Sixteen 4-bit channel registers feeding the external 16:1 nibble mux.
// One write port; every register is visible on its own output a0..a15.
module nibble_bank
    import nibble_scan_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [CH_W-1:0]  wr_addr,
    input  logic [NIB_W-1:0] wr_data,
    output logic [NIB_W-1:0] a0,
    output logic [NIB_W-1:0] a1,
    output logic [NIB_W-1:0] a2,
    output logic [NIB_W-1:0] a3,
    output logic [NIB_W-1:0] a4,
    output logic [NIB_W-1:0] a5,
    output logic [NIB_W-1:0] a6,
    output logic [NIB_W-1:0] a7,
    output logic [NIB_W-1:0] a8,
    output logic [NIB_W-1:0] a9,
    output logic [NIB_W-1:0] a10,
    output logic [NIB_W-1:0] a11,
    output logic [NIB_W-1:0] a12,
    output logic [NIB_W-1:0] a13,
    output logic [NIB_W-1:0] a14,
    output logic [NIB_W-1:0] a15
);

    logic [NIB_W-1:0] bank_q [CH_N];

    // Register file: cleared on reset, one channel written per cycle.
    // NOTE: the bank is small and drives the mux directly, so it is reset like
    // ordinary flops; a large RAM would normally be left unreset. Sequential
    // state is assigned with <= so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < CH_N; i++) begin
                bank_q[i] <= '0;
            end
        end else if (wr_en) begin
            bank_q[wr_addr] <= wr_data;
        end
    end

    assign a0  = bank_q[0];
    assign a1  = bank_q[1];
    assign a2  = bank_q[2];
    assign a3  = bank_q[3];
    assign a4  = bank_q[4];
    assign a5  = bank_q[5];
    assign a6  = bank_q[6];
    assign a7  = bank_q[7];
    assign a8  = bank_q[8];
    assign a9  = bank_q[9];
    assign a10 = bank_q[10];
    assign a11 = bank_q[11];
    assign a12 = bank_q[12];
    assign a13 = bank_q[13];
    assign a14 = bank_q[14];
    assign a15 = bank_q[15];

endmodule

// File: rtl/nibble_scan_seq.sv
// Scan sequencer in front of the external 16:1 nibble mux. Holds the channel
// bank, steps the registered mux select through channels 0..LAST_CH, captures
// the nibble the mux returns and streams it out with valid/ready and the
// channel index.
// Optional build macro SCAN_LOOP_EN: scanning wraps continuously until stop.
module nibble_scan_seq
    import nibble_scan_pkg::*;
#(
    parameter int LAST_CH = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [CH_W-1:0]  wr_addr,
    input  logic [NIB_W-1:0] wr_data,
    input  logic             start,
    input  logic             stop,
    output logic [NIB_W-1:0] a0,
    output logic [NIB_W-1:0] a1,
    output logic [NIB_W-1:0] a2,
    output logic [NIB_W-1:0] a3,
    output logic [NIB_W-1:0] a4,
    output logic [NIB_W-1:0] a5,
    output logic [NIB_W-1:0] a6,
    output logic [NIB_W-1:0] a7,
    output logic [NIB_W-1:0] a8,
    output logic [NIB_W-1:0] a9,
    output logic [NIB_W-1:0] a10,
    output logic [NIB_W-1:0] a11,
    output logic [NIB_W-1:0] a12,
    output logic [NIB_W-1:0] a13,
    output logic [NIB_W-1:0] a14,
    output logic [NIB_W-1:0] a15,
    output logic [CH_W-1:0]  s,
    input  logic [NIB_W-1:0] mux_out,
    output logic [NIB_W-1:0] data_out,
    output logic [CH_W-1:0]  data_ch,
    output logic             data_valid,
    input  logic             data_ready,
    output logic             busy,
    output logic             done
);

    localparam logic [CH_W-1:0] LAST = CH_W'(LAST_CH);

    scan_state_e      state_q, state_d;
    logic [CH_W-1:0]  s_q, s_d;
    logic [NIB_W-1:0] dout_q, dout_d;
    logic [CH_W-1:0]  dch_q, dch_d;
    logic             dvalid_q, dvalid_d;
    logic             done_q, done_d;
    logic             load;
    logic             xfer;
`ifdef SCAN_LOOP_EN
    logic             stop_pend_q, stop_pend_d;
    logic             final_load;
`else
    logic             unused_stop;
    assign unused_stop = stop;
`endif

    nibble_bank u_bank (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .a0 (a0),   .a1 (a1),   .a2 (a2),   .a3 (a3),
        .a4 (a4),   .a5 (a5),   .a6 (a6),   .a7 (a7),
        .a8 (a8),   .a9 (a9),   .a10(a10),  .a11(a11),
        .a12(a12),  .a13(a13),  .a14(a14),  .a15(a15)
    );

    // The output slot accepts a new nibble when empty or being drained.
    assign load = !dvalid_q || data_ready;
    assign xfer = dvalid_q && data_ready;

    // Next-state logic: scan stepping, output capture and pass completion.
    // NOTE: every signal gets its hold value before the case statement, so no
    // path leaves a variable unassigned and no latch is inferred.
    always_comb begin
        state_d  = state_q;
        s_d      = s_q;
        dout_d   = dout_q;
        dch_d    = dch_q;
        dvalid_d = dvalid_q;
        done_d   = 1'b0;
`ifdef SCAN_LOOP_EN
        stop_pend_d = stop_pend_q;
        final_load  = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                s_d = '0;
`ifdef SCAN_LOOP_EN
                stop_pend_d = 1'b0;
`endif
                if (start) begin
                    state_d = SCAN;
                end
            end
            SCAN: begin
                if (load) begin
                    // The mux is looking at s_q this cycle; capture its answer.
                    dout_d   = mux_out;
                    dch_d    = s_q;
                    dvalid_d = 1'b1;
`ifdef SCAN_LOOP_EN
                    // A stop seen now or at an earlier stalled edge makes this
                    // the last channel of the run.
                    final_load = stop || stop_pend_q;
                    if (final_load) begin
                        state_d     = DRAIN;
                        stop_pend_d = 1'b0;
                    end else begin
                        s_d = next_ch(s_q, LAST);
                    end
`else
                    if (s_q == LAST) begin
                        state_d = DRAIN;
                    end else begin
                        s_d = next_ch(s_q, LAST);
                    end
`endif
                end
`ifdef SCAN_LOOP_EN
                else if (stop) begin
                    stop_pend_d = 1'b1;
                end
`endif
            end
            DRAIN: begin
                if (xfer) begin
                    dvalid_d = 1'b0;
                    done_d   = 1'b1;
                    s_d      = '0;
                    state_d  = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                s_d     = '0;
            end
        endcase
    end

    // State, select and output registers; reset aborts any pass in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            s_q      <= '0;
            dout_q   <= '0;
            dch_q    <= '0;
            dvalid_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            s_q      <= s_d;
            dout_q   <= dout_d;
            dch_q    <= dch_d;
            dvalid_q <= dvalid_d;
            done_q   <= done_d;
        end
    end

`ifdef SCAN_LOOP_EN
    // Remembers a stop request that arrived while the output was stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stop_pend_q <= 1'b0;
        end else begin
            stop_pend_q <= stop_pend_d;
        end
    end
`endif

    assign s          = s_q;
    assign data_out   = dout_q;
    assign data_ch    = dch_q;
    assign data_valid = dvalid_q;
    assign done       = done_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_nibble_scan_seq.sv
// Self-checking bench for nibble_scan_seq: a vector table for one full pass,
// hand-written multi-cycle corner cases, and randomized passes checked
// against a bank/stream model. Build with SCAN_LOOP_EN to exercise looping.
module tb_nibble_scan_seq;

    typedef struct packed {
        logic [3:0] ch;
        logic [3:0] data;
    } xfer_t;

    typedef struct {
        logic       start;
        logic       ready;
        logic       exp_valid;
        logic [3:0] exp_ch;
        logic [3:0] exp_data;
        logic [3:0] exp_s;
        logic       exp_busy;
        logic       exp_done;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // DUT 0 (LAST_CH = 15)
    logic       rst, wr_en, start, stop, data_ready;
    logic [3:0] wr_addr, wr_data, mux_out, s, data_out, data_ch;
    logic       data_valid, busy, done;
    logic [3:0] a0, a1, a2, a3, a4, a5, a6, a7, a8, a9, a10, a11, a12, a13, a14, a15;
    logic [63:0] a_flat;
    assign a_flat  = {a15, a14, a13, a12, a11, a10, a9, a8, a7, a6, a5, a4, a3, a2, a1, a0};
    assign mux_out = a_flat[{s, 2'b00} +: 4];

    // DUT 1 (LAST_CH = 0)
    logic       wr_en1, start1, stop1, data_ready1;
    logic [3:0] wr_addr1, wr_data1, mux_out1, s1, data_out1, data_ch1;
    logic       data_valid1, busy1, done1;
    logic [3:0] b0, b1, b2, b3, b4, b5, b6, b7, b8, b9, b10, b11, b12, b13, b14, b15;
    logic [63:0] b_flat;
    assign b_flat   = {b15, b14, b13, b12, b11, b10, b9, b8, b7, b6, b5, b4, b3, b2, b1, b0};
    assign mux_out1 = b_flat[{s1, 2'b00} +: 4];

    nibble_scan_seq #(.LAST_CH(15)) u_dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .start(start), .stop(stop),
        .a0(a0), .a1(a1), .a2(a2), .a3(a3), .a4(a4), .a5(a5), .a6(a6), .a7(a7),
        .a8(a8), .a9(a9), .a10(a10), .a11(a11), .a12(a12), .a13(a13), .a14(a14), .a15(a15),
        .s(s), .mux_out(mux_out), .data_out(data_out), .data_ch(data_ch),
        .data_valid(data_valid), .data_ready(data_ready), .busy(busy), .done(done)
    );

    nibble_scan_seq #(.LAST_CH(0)) u_dut1 (
        .clk(clk), .rst(rst), .wr_en(wr_en1), .wr_addr(wr_addr1), .wr_data(wr_data1),
        .start(start1), .stop(stop1),
        .a0(b0), .a1(b1), .a2(b2), .a3(b3), .a4(b4), .a5(b5), .a6(b6), .a7(b7),
        .a8(b8), .a9(b9), .a10(b10), .a11(b11), .a12(b12), .a13(b13), .a14(b14), .a15(b15),
        .s(s1), .mux_out(mux_out1), .data_out(data_out1), .data_ch(data_ch1),
        .data_valid(data_valid1), .data_ready(data_ready1), .busy(busy1), .done(done1)
    );

    // Reference model state
    logic [3:0] tb_bank [16];
    xfer_t      exp_q[$];
    xfer_t      got_q[$];
    int         done_cnt = 0;
    int         done_base = 0;
    vec_t       vecs [19];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor on the falling edge: records transfers, counts done pulses and
    // checks that a stalled output and the select stay frozen.
    logic       prev_stall = 1'b0;
    logic [3:0] prev_s, prev_dout, prev_dch;
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_data_out", data_out, prev_dout);
                check("stall_data_ch", data_ch, prev_dch);
                check("stall_s", s, prev_s);
            end
            if (data_valid && data_ready) begin
                got_q.push_back({data_ch, data_out});
            end
            if (done) begin
                done_cnt++;
            end
            prev_stall = data_valid && !data_ready;
            prev_s     = s;
            prev_dout  = data_out;
            prev_dch   = data_ch;
        end
    end

    task automatic bank_write(input logic [3:0] addr, input logic [3:0] data);
        wr_en   = 1'b1;
        wr_addr = addr;
        wr_data = data;
        @(posedge clk); #1;
        wr_en = 1'b0;
        tb_bank[addr] = data;
    endtask

    task automatic model_reset();
        for (int k = 0; k < 16; k++) tb_bank[k] = 4'h0;
    endtask

    task automatic build_exp();
        exp_q.delete();
        for (int k = 0; k < 16; k++) exp_q.push_back({4'(k), tb_bank[k]});
    endtask

    task automatic check_bank(input string tag);
        logic [63:0] flat;
        for (int k = 0; k < 16; k++) flat[k*4 +: 4] = tb_bank[k];
        check(tag, a_flat, flat);
    endtask

    task automatic start_pass();
        got_q.delete();
        done_base  = done_cnt;
        start      = 1'b1;
        data_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // ready_mode: 0 always ready, 1 toggling, 2 random. poke: random start
    // pulses while busy (and random stop in the single-pass build).
    task automatic wait_done(input int ready_mode, input bit poke);
        int cyc = 0;
        while (done_cnt == done_base && cyc < 400) begin
            case (ready_mode)
                0:       data_ready = 1'b1;
                1:       data_ready = (cyc % 2 == 0);
                default: data_ready = 1'($urandom_range(0, 1));
            endcase
            if (poke) begin
                start = busy && ($urandom_range(0, 3) == 0);
`ifndef SCAN_LOOP_EN
                stop  = 1'($urandom_range(0, 1));
`endif
            end
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0;
        stop  = 1'b0;
        data_ready = 1'b1;
        check("pass_timeout", 32'(cyc < 400), 1);
        repeat (3) begin
            @(posedge clk); #1;
        end
        check("done_once", done_cnt - done_base, 1);
        check("busy_after", busy, 0);
    endtask

    task automatic compare_stream(input string tag);
        check({tag, "_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            check({tag, "_ch"}, got_q[i].ch, exp_q[i].ch);
            check({tag, "_data"}, got_q[i].data, exp_q[i].data);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        start = 1'b0; stop = 1'b0; data_ready = 1'b1;
        wr_en1 = 1'b0; wr_addr1 = '0; wr_data1 = '0;
        start1 = 1'b0; stop1 = 1'b0; data_ready1 = 1'b1;
        model_reset();

        // Vector table for one back-to-back pass with bank[k] = k ^ F.
        vecs[0] = '{1'b1, 1'b1, 1'b0, 4'h0, 4'h0, 4'h0, 1'b1, 1'b0};
        for (int k = 0; k < 16; k++) begin
            vecs[k+1] = '{1'b0, 1'b1, 1'b1, 4'(k), 4'(k ^ 15),
                          (k == 15) ? 4'hF : 4'(k + 1), 1'b1, 1'b0};
        end
        vecs[17] = '{1'b0, 1'b1, 1'b0, 4'hF, 4'h0, 4'h0, 1'b0, 1'b1};
        vecs[18] = '{1'b0, 1'b1, 1'b0, 4'hF, 4'h0, 4'h0, 1'b0, 1'b0};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", data_valid, 0);
        check("rst_data_out", data_out, 0);
        check("rst_data_ch", data_ch, 0);
        check("rst_s", s, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_bank", a_flat, 0);
        check("rst_busy1", busy1, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int k = 0; k < 16; k++) bank_write(4'(k), 4'(k ^ 15));
        check_bank("bank_fill");

`ifdef SCAN_LOOP_EN
        // Continuous scan: 20 loads, stop at s=4, final channel 4 (or 5).
        start_pass();
        repeat (20) begin
            @(posedge clk); #1;
        end
        check("loop_s_at_stop", s, 4);
        stop = 1'b1;
        @(posedge clk); #1;
        stop = 1'b0;
        wait_done(0, 1'b0);
        check("loop_len", 32'(got_q.size() == 21 || got_q.size() == 22), 1);
        for (int i = 0; i < got_q.size(); i++) begin
            check("loop_ch", got_q[i].ch, 4'(i % 16));
            check("loop_data", got_q[i].data, 4'((i % 16) ^ 15));
        end
`else
        // Table-driven full pass
        for (int i = 0; i < 19; i++) begin
            start      = vecs[i].start;
            data_ready = vecs[i].ready;
            @(posedge clk); #1;
            check($sformatf("vec%0d_valid", i), data_valid, vecs[i].exp_valid);
            check($sformatf("vec%0d_ch", i), data_ch, vecs[i].exp_ch);
            check($sformatf("vec%0d_data", i), data_out, vecs[i].exp_data);
            check($sformatf("vec%0d_s", i), s, vecs[i].exp_s);
            check($sformatf("vec%0d_busy", i), busy, vecs[i].exp_busy);
            check($sformatf("vec%0d_done", i), done, vecs[i].exp_done);
        end
        start = 1'b0;

        // Toggling ready: same stream, nothing duplicated or dropped.
        build_exp();
        start_pass();
        wait_done(1, 1'b0);
        compare_stream("toggle");

        // Reset after the 5th transfer aborts the pass without done.
        begin
            int cyc = 0;
            build_exp();
            start_pass();
            while (got_q.size() < 5 && cyc < 50) begin
                @(posedge clk); #1;
                cyc++;
            end
            check("abort_xfers", got_q.size(), 5);
            for (int i = 0; i < 5 && i < got_q.size(); i++) begin
                check("abort_ch", got_q[i].ch, exp_q[i].ch);
                check("abort_data", got_q[i].data, exp_q[i].data);
            end
            rst = 1'b1;
            @(posedge clk); #1;
            model_reset();
            check("abort_valid", data_valid, 0);
            check("abort_data_out", data_out, 0);
            check("abort_data_ch", data_ch, 0);
            check("abort_s", s, 0);
            check("abort_busy", busy, 0);
            check("abort_bank", a_flat, 0);
            rst = 1'b0;
            repeat (3) begin
                @(posedge clk); #1;
            end
            check("abort_no_done", done_cnt - done_base, 0);
        end
        for (int k = 0; k < 16; k++) bank_write(4'(k), 4'($urandom_range(0, 15)));
        build_exp();
        start_pass();
        wait_done(0, 1'b0);
        compare_stream("replay");

        // Write to channel 7 in the cycle it is captured: old value wins.
        begin
            int cyc = 0;
            bank_write(4'd7, 4'hA);
            build_exp();
            start_pass();
            while (s != 4'd7 && cyc < 50) begin
                @(posedge clk); #1;
                cyc++;
            end
            check("wr_race_reach_s7", s, 7);
            wr_en = 1'b1; wr_addr = 4'd7; wr_data = 4'h3;
            @(posedge clk); #1;
            wr_en = 1'b0;
            tb_bank[7] = 4'h3;
            wait_done(0, 1'b0);
            compare_stream("wr_race_old");
            build_exp();
            check("wr_race_model", exp_q[7].data, 4'h3);
            start_pass();
            wait_done(0, 1'b0);
            compare_stream("wr_race_new");
        end

        // Randomized passes: random bank, random backpressure, start/stop noise.
        for (int p = 0; p < 4; p++) begin
            for (int k = 0; k < 16; k++) bank_write(4'(k), 4'($urandom_range(0, 15)));
            check_bank("rand_bank");
            build_exp();
            start_pass();
            wait_done(2, 1'b1);
            compare_stream("rand");
        end

        // LAST_CH = 0: exactly one transfer; start while busy is ignored.
        wr_en1 = 1'b1; wr_addr1 = 4'd0; wr_data1 = 4'h5;
        @(posedge clk); #1;
        wr_addr1 = 4'd1; wr_data1 = 4'h9;
        @(posedge clk); #1;
        wr_en1 = 1'b0;
        start1 = 1'b1; data_ready1 = 1'b1;
        @(posedge clk); #1;
        check("ch0_start_valid", data_valid1, 0);
        check("ch0_start_busy", busy1, 1);
        check("ch0_start_s", s1, 0);
        @(posedge clk); #1;
        check("ch0_load_valid", data_valid1, 1);
        check("ch0_load_ch", data_ch1, 0);
        check("ch0_load_data", data_out1, 5);
        check("ch0_load_busy", busy1, 1);
        @(posedge clk); #1;
        check("ch0_done", done1, 1);
        check("ch0_done_valid", data_valid1, 0);
        check("ch0_done_busy", busy1, 0);
        start1 = 1'b0;
        @(posedge clk); #1;
        check("ch0_done_pulse", done1, 0);
        check("ch0_idle_busy", busy1, 0);
        check("ch0_idle_valid", data_valid1, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
